round_key_sched: RTL and testbench
==================================

// Module: round_key_sched
// PURPOSE
//  Round-key bank and sequencer between key_exp and the AES-128 round engine.
//  - Waits for key_exp to settle after a new cipher key, then captures all 11 round keys.
//  - Streams one key per valid/ready beat to the round engine, index 0..10.
//  - key_r is the round-0 (original) key; key_rN is the round N+1 key.
// PARAMETERS
//  KEXP_LAT  10  cycles from key_load sample edge to key_exp outputs valid (>=1)
//  CNT_W     4   width of settle counter and rk_idx (must hold max(KEXP_LAT,10))
// PORTS
//  clk       in   1    clock, rising edge
//  rst       in   1    asynchronous, active-low reset
//  key_load  in   1    pulse: new cipher key applied to key_exp this cycle
//  key_r     in   128  round-0 key from key_exp
//  key_r0..key_r9 in 128 each  round 1..10 keys from key_exp
//  rk_start  in   1    request a key stream (honoured only in READY)
//  rk_ready  in   1    consumer accepts rk_out this cycle
//  rk_out    out  128  current round key; 0 when rk_valid=0
//  rk_idx    out  CNT_W  round index of rk_out; 0 when rk_valid=0
//  rk_valid  out  1    rk_out valid
//  rk_last   out  1    rk_valid & final index of the stream
//  ks_ready  out  1    bank holds a complete, settled key schedule
// BEHAVIOUR
//  - Reset (rst=0, any time): state IDLE, bank cleared to 0, settle counter 0,
//    all outputs 0. Takes effect immediately, independent of clk.
//  - FSM states: IDLE, WAIT, READY, STREAM.
//    IDLE   -> WAIT on key_load.
//    WAIT   counter increments each edge from 0; at edge where counter==KEXP_LAT-1,
//           capture key_r..key_r9 into bank[0..10], go READY.
//           ks_ready=1 after edge KEXP_LAT, counting the key_load edge as edge 0.
//    READY  rk_start -> STREAM with idx=0; rk_valid=1 from the next cycle.
//    STREAM rk_out=bank[idx] (combinational from registered idx).
//           On rk_valid&rk_ready: if idx==10 -> READY, rk_valid=0 next cycle;
//           else idx+1.
//           rk_ready low: rk_out and rk_idx held stable.
//  - key_load from any state:
//    - -> WAIT, counter=0, ks_ready=0 next cycle, rk_valid=0 next cycle (stream aborted).
//    - A handshake in the same cycle completes, but no further beats are issued.
//  - key_load with rk_start in the same cycle: key_load wins; rk_start is dropped.
//  - rk_start outside READY is ignored. Fully streamed bank stays valid; restartable.
//  - Back-to-back streams: earliest rk_start is the cycle rk_valid is 0 after the last beat.
//  - Throughput: 1 key/cycle with rk_ready held high; 11 beats per stream.
// CONFIGURATION
//  RK_DEC_ORDER_EN defined:
//    - Adds input port rk_dec (1 bit), sampled with rk_start.
//    - rk_dec=1: idx starts at 10 and decrements; rk_last at idx 0.
//    - rk_dec=0: forward order.
//  RK_DEC_ORDER_EN undefined: no rk_dec port; forward order only.
// TESTING
//  Drive key_r..key_r9 from real key_exp, key 2b7e1516_28aed2a6_abf71588_09cf4f3c, KEXP_LAT=10.
//  1. rst=0 mid-STREAM -> rk_valid, rk_out, rk_idx, rk_last, ks_ready all 0 with no clk edge;
//     rk_start after rst=1 ignored.
//  2. key_load pulse -> ks_ready=0 through edge 9, ks_ready=1 after edge 10.
//  3. rk_start, rk_ready=1 -> 11 consecutive beats, idx 0..10:
//     beat0=2b7e1516..., beat1=a0fafe17_88542cb1_23a33939_2a6c7605,
//     beat10=d014f9a8_c9ee2589_e13f0cc8_b6630ca6; rk_last only on beat10.
//  4. rk_ready alternating 1/0 -> 21 cycles for 11 beats; rk_out and rk_idx stable on stall cycles.
//  5. key_load accepted while idx=5 -> rk_valid=0 next cycle, ks_ready=0; rk_start ignored;
//     ks_ready back to 1 10 edges later.
//  6. RK_DEC_ORDER_EN, rk_dec=1 -> beat0=d014f9a8..., idx 10..0, beat10=2b7e1516..., rk_last at idx 0.

Source files
------------

// File: rtl/round_key_sched.sv
// Round-key bank and sequencer: captures the AES-128 key schedule once key_exp settles,
// then streams it to the round engine over valid/ready. Optional macro RK_DEC_ORDER_EN adds rk_dec.
module round_key_sched #(
    parameter int unsigned KEXP_LAT = 10,
    parameter int unsigned CNT_W    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_load,
    input  logic [127:0]       key_r,
    input  logic [127:0]       key_r0,
    input  logic [127:0]       key_r1,
    input  logic [127:0]       key_r2,
    input  logic [127:0]       key_r3,
    input  logic [127:0]       key_r4,
    input  logic [127:0]       key_r5,
    input  logic [127:0]       key_r6,
    input  logic [127:0]       key_r7,
    input  logic [127:0]       key_r8,
    input  logic [127:0]       key_r9,
    input  logic               rk_start,
    input  logic               rk_ready,
`ifdef RK_DEC_ORDER_EN
    input  logic               rk_dec,
`endif
    output logic [127:0]       rk_out,
    output logic [CNT_W-1:0]   rk_idx,
    output logic               rk_valid,
    output logic               rk_last,
    output logic               ks_ready
);

    localparam int unsigned NUM_KEYS = 11;
    localparam int unsigned KEY_W    = 128;
    localparam logic [CNT_W-1:0] IDX_LAST   = CNT_W'(NUM_KEYS - 1);
    localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(KEXP_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_READY,
        S_STREAM
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             dec_q;
    logic [KEY_W-1:0] bank   [NUM_KEYS];
    logic [KEY_W-1:0] key_in [NUM_KEYS];
    logic             dec_start;
    logic [CNT_W-1:0] idx_end;
    logic [CNT_W-1:0] idx_step;

    assign key_in[0]  = key_r;
    assign key_in[1]  = key_r0;
    assign key_in[2]  = key_r1;
    assign key_in[3]  = key_r2;
    assign key_in[4]  = key_r3;
    assign key_in[5]  = key_r4;
    assign key_in[6]  = key_r5;
    assign key_in[7]  = key_r6;
    assign key_in[8]  = key_r7;
    assign key_in[9]  = key_r8;
    assign key_in[10] = key_r9;

`ifdef RK_DEC_ORDER_EN
    assign dec_start = rk_dec;
`else
    assign dec_start = 1'b0;
`endif

    // Stream direction is latched at start so the order cannot change mid-stream.
    assign idx_end  = dec_q ? '0 : IDX_LAST;
    assign idx_step = dec_q ? rk_idx - CNT_W'(1) : rk_idx + CNT_W'(1);

    // rk_idx is held at 0 whenever rk_valid is low, so only the key needs gating.
    assign rk_out = rk_valid ? bank[rk_idx] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            dec_q    <= 1'b0;
            rk_idx   <= '0;
            rk_valid <= 1'b0;
            rk_last  <= 1'b0;
            ks_ready <= 1'b0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                bank[i] <= '0;
            end
        end else if (key_load) begin
            // New cipher key overrides everything, including a pending rk_start.
            state    <= S_WAIT;
            cnt      <= '0;
            rk_idx   <= '0;
            rk_valid <= 1'b0;
            rk_last  <= 1'b0;
            ks_ready <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    state <= S_IDLE;
                end
                S_WAIT: begin
                    if (cnt == SETTLE_END) begin
                        for (int i = 0; i < NUM_KEYS; i++) begin
                            bank[i] <= key_in[i];
                        end
                        cnt      <= '0;
                        ks_ready <= 1'b1;
                        state    <= S_READY;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_READY: begin
                    if (rk_start) begin
                        state    <= S_STREAM;
                        dec_q    <= dec_start;
                        rk_idx   <= dec_start ? IDX_LAST : '0;
                        rk_valid <= 1'b1;
                        rk_last  <= 1'b0;
                    end
                end
                S_STREAM: begin
                    if (rk_ready) begin
                        if (rk_idx == idx_end) begin
                            state    <= S_READY;
                            rk_idx   <= '0;
                            rk_valid <= 1'b0;
                            rk_last  <= 1'b0;
                        end else begin
                            rk_idx  <= idx_step;
                            rk_last <= (idx_step == idx_end);
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_round_key_sched.sv
// Self-checking bench for round_key_sched using the FIPS-197 example key schedule
// and a scoreboard queue of expected stream beats.
module tb_round_key_sched;

    localparam int unsigned KEXP_LAT = 10;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned NUM_KEYS = 11;

    typedef struct packed {
        logic [CNT_W-1:0] idx;
        logic [127:0]     key;
        logic             last;
    } beat_t;

    logic               clk;
    logic               rst;
    logic               key_load;
    logic               rk_start;
    logic               rk_ready;
`ifdef RK_DEC_ORDER_EN
    logic               rk_dec;
`endif
    logic [127:0]       kin [NUM_KEYS];
    logic [127:0]       rk_out;
    logic [CNT_W-1:0]   rk_idx;
    logic               rk_valid;
    logic               rk_last;
    logic               ks_ready;

    logic [127:0]       rks       [NUM_KEYS];
    logic [127:0]       exp_bank  [NUM_KEYS];
    beat_t              sb [$];
    int                 n_run;
    int                 n_fail;
    int                 cyc;

    round_key_sched #(.KEXP_LAT(KEXP_LAT), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .key_load (key_load),
        .key_r    (kin[0]),
        .key_r0   (kin[1]),
        .key_r1   (kin[2]),
        .key_r2   (kin[3]),
        .key_r3   (kin[4]),
        .key_r4   (kin[5]),
        .key_r5   (kin[6]),
        .key_r6   (kin[7]),
        .key_r7   (kin[8]),
        .key_r8   (kin[9]),
        .key_r9   (kin[10]),
        .rk_start (rk_start),
        .rk_ready (rk_ready),
`ifdef RK_DEC_ORDER_EN
        .rk_dec   (rk_dec),
`endif
        .rk_out   (rk_out),
        .rk_idx   (rk_idx),
        .rk_valid (rk_valid),
        .rk_last  (rk_last),
        .ks_ready (ks_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // key_exp model: outputs are junk until just before the settle edge, then the new schedule.
    task automatic load_key(input bit inv);
        for (int i = 0; i < NUM_KEYS; i++) begin
            exp_bank[i] = inv ? ~rks[i] : rks[i];
            kin[i]      = {96'h0, 32'hbad0_0000 | 32'(i)};
        end
        key_load = 1'b1;
        rk_start = 1'b1;
        tick;
        key_load = 1'b0;
        chk_b("kl_valid_drop", rk_valid, 1'b0);
        chk_b("kl_ks_drop", ks_ready, 1'b0);
        for (int e = 1; e <= KEXP_LAT; e++) begin
            if (e == KEXP_LAT) begin
                rk_start = 1'b0;
                for (int i = 0; i < NUM_KEYS; i++) kin[i] = exp_bank[i];
            end
            tick;
            chk_b((e < KEXP_LAT) ? "ks_settling" : "ks_settled", ks_ready, (e == KEXP_LAT));
            if (e < KEXP_LAT) chk_b("start_ignored_wait", rk_valid, 1'b0);
        end
    endtask

    // Push the expected stream, request it, and compare beats as they are accepted.
    task automatic stream(input logic dec, input bit alt, input int n_beats, output int ncyc);
        int               popped;
        logic             stalled;
        logic [127:0]     p_out;
        logic [CNT_W-1:0] p_idx;
        beat_t            b;
        popped  = 0;
        stalled = 1'b0;
        p_out   = '0;
        p_idx   = '0;
        ncyc    = 0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            b.idx  = dec ? CNT_W'(NUM_KEYS - 1 - k) : CNT_W'(k);
            b.key  = exp_bank[b.idx];
            b.last = (k == NUM_KEYS - 1);
            sb.push_back(b);
        end
`ifdef RK_DEC_ORDER_EN
        rk_dec = dec;
`endif
        rk_start = 1'b1;
        tick;
        rk_start = 1'b0;
        for (int t = 0; t < 4 * NUM_KEYS && popped < n_beats; t++) begin
            chk_b("stream_valid", rk_valid, 1'b1);
            chk("beat_idx", 128'(rk_idx), 128'(sb[0].idx));
            chk("beat_key", rk_out, sb[0].key);
            chk_b("beat_last", rk_last, sb[0].last);
            if (stalled) begin
                chk("stall_key", rk_out, p_out);
                chk("stall_idx", 128'(rk_idx), 128'(p_idx));
            end
            rk_ready = !alt || (ncyc % 2 == 0);
            stalled  = !rk_ready;
            p_out    = rk_out;
            p_idx    = rk_idx;
            if (rk_ready && rk_valid) begin
                void'(sb.pop_front());
                popped++;
            end
            ncyc++;
            tick;
        end
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        rks[0]  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
        rks[1]  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
        rks[2]  = 128'hf2c295f2_7a96b943_5935807a_7359f67f;
        rks[3]  = 128'h3d80477d_4716fe3e_1e237e44_6d7a883b;
        rks[4]  = 128'hef44a541_a8525b7f_b671253b_db0bad00;
        rks[5]  = 128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc;
        rks[6]  = 128'h6d88a37a_110b3efd_dbf98641_ca0093fd;
        rks[7]  = 128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f;
        rks[8]  = 128'head27321_b58dbad2_312bf560_7f8d292f;
        rks[9]  = 128'hac7766f3_19fadc21_28d12941_575c006e;
        rks[10] = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
        for (int i = 0; i < NUM_KEYS; i++) begin
            kin[i]      = '0;
            exp_bank[i] = '0;
        end
        key_load = 1'b0;
        rk_start = 1'b0;
        rk_ready = 1'b0;
`ifdef RK_DEC_ORDER_EN
        rk_dec = 1'b0;
`endif
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk_b("rst_valid", rk_valid, 1'b0);
        chk_b("rst_ks_ready", ks_ready, 1'b0);
        chk("rst_out", rk_out, 128'h0);
        tick;
        rst = 1'b1;

        // rk_start in IDLE does nothing
        rk_start = 1'b1;
        tick;
        rk_start = 1'b0;
        chk_b("idle_start_ignored", rk_valid, 1'b0);

        // Settle timing and first forward stream
        load_key(1'b0);
        stream(1'b0, 1'b0, NUM_KEYS, cyc);
        chk("fwd_cycles", 128'(cyc), 128'(NUM_KEYS));
        chk("fwd_sb_empty", 128'(sb.size()), 128'(0));
        chk_b("fwd_valid_drop", rk_valid, 1'b0);

        // Back-to-back stream with rk_ready alternating
        stream(1'b0, 1'b1, NUM_KEYS, cyc);
        chk("alt_cycles", 128'(cyc), 128'(2 * NUM_KEYS - 1));
        chk("alt_sb_empty", 128'(sb.size()), 128'(0));
        chk_b("alt_valid_drop", rk_valid, 1'b0);
        chk_b("bank_still_ready", ks_ready, 1'b1);

        // Abort at idx 5 with a new key; the idx-5 handshake completes in the load cycle
        stream(1'b0, 1'b0, 5, cyc);
        chk("abort_idx", 128'(rk_idx), 128'(5));
        sb.delete();
        rk_ready = 1'b1;
        load_key(1'b1);
        stream(1'b0, 1'b0, NUM_KEYS, cyc);
        chk("reload_cycles", 128'(cyc), 128'(NUM_KEYS));
        chk("reload_sb_empty", 128'(sb.size()), 128'(0));

        // key_load with rk_start in READY: load wins
        load_key(1'b0);
`ifdef RK_DEC_ORDER_EN
        stream(1'b1, 1'b0, NUM_KEYS, cyc);
        chk("dec_cycles", 128'(cyc), 128'(NUM_KEYS));
        chk("dec_sb_empty", 128'(sb.size()), 128'(0));
        chk_b("dec_valid_drop", rk_valid, 1'b0);
`endif

        // Asynchronous reset mid-stream, no clock edge in between
        stream(1'b0, 1'b0, 4, cyc);
        sb.delete();
        rst = 1'b0;
        #1;
        chk_b("arst_valid", rk_valid, 1'b0);
        chk("arst_out", rk_out, 128'h0);
        chk("arst_idx", 128'(rk_idx), 128'(0));
        chk_b("arst_last", rk_last, 1'b0);
        chk_b("arst_ks_ready", ks_ready, 1'b0);
        #2 rst = 1'b1;
        rk_start = 1'b1;
        tick;
        tick;
        rk_start = 1'b0;
        chk_b("post_rst_start_ignored", rk_valid, 1'b0);
        chk_b("post_rst_ks_ready", ks_ready, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
